heepstor_exit_reporter: RTL and testbench



---
 rtl/heepstor_exit_pkg.sv | 28 ++
 rtl/heepstor_exit_reporter_if.sv | 17 +
 rtl/heepstor_uart_tx_byte.sv | 101 ++++++++++
 rtl/heepstor_exit_reporter.sv | 168 ++++++++++++++++
 tb/tb_heepstor_exit_reporter.sv | 339 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/heepstor_exit_pkg.sv
// Shared types and constants for the exit reporter: serialiser states, message layout
// and the nibble-to-ASCII helper.
package heepstor_exit_pkg;

  localparam int unsigned MSG_LEN = 15;

  localparam logic [39:0] MSG_PREFIX = "EXIT=";
  localparam logic [7:0]  ASCII_CR   = 8'h0D;
  localparam logic [7:0]  ASCII_LF   = 8'h0A;

  // StNext has no cycle of its own: the hand-off to the next byte happens in the
  // last cycle of the stop bit, so back-to-back bytes have no gap.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StNext
  } tx_state_e;

  function automatic logic [7:0] hex_ascii(logic [3:0] nib);
    if (nib < 4'd10) begin
      return 8'h30 + {4'h0, nib};
    end
    return 8'h37 + {4'h0, nib};
  endfunction

endpackage

// File: rtl/heepstor_exit_reporter_if.sv
// SoC exit-status pair as seen from the FPGA wrapper.
interface heepstor_exit_reporter_if;

  logic        exit_valid_i;
  logic [31:0] exit_value_i;

  modport master (
    output exit_valid_i,
    output exit_value_i
  );

  modport slave (
    input exit_valid_i,
    input exit_value_i
  );

endinterface

// File: rtl/heepstor_uart_tx_byte.sv
// 8N1 bit-level serialiser with a byte valid/ready handshake. Every bit lasts DIV cycles;
// a byte offered during the last stop-bit cycle starts with no idle gap.
module heepstor_uart_tx_byte
  import heepstor_exit_pkg::*;
#(
  parameter int unsigned DIV = 10
) (
  input  logic       clk_gen,
  input  logic       rst_n,
  input  logic       byte_valid,
  input  logic [7:0] byte_data,
  output logic       byte_ready,
  output logic       done,
  output logic       tx
);

  localparam int unsigned CntW = (DIV < 2) ? 1 : $clog2(DIV);
  localparam logic [CntW-1:0] CntMax = CntW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("heepstor_uart_tx_byte: DIV must be at least 2");
  end

  tx_state_e       state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      bit_q;
  logic [7:0]      shift_q;
  logic            tx_q;
  logic            tick;

  assign tick       = (cnt_q == CntMax);
  assign done       = (state_q == StStop) && tick;
  assign byte_ready = (state_q == StIdle) || done;
  assign tx         = tx_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      tx_q    <= 1'b1;
    end else begin
      case (state_q)
        StIdle: begin
          cnt_q <= '0;
          if (byte_valid) begin
            state_q <= StStart;
            shift_q <= byte_data;
            tx_q    <= 1'b0;
          end
        end
        StStart: begin
          if (tick) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            tx_q    <= shift_q[0];
            state_q <= StData;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StData: begin
          if (tick) begin
            cnt_q <= '0;
            if (bit_q == 3'd7) begin
              state_q <= StStop;
              tx_q    <= 1'b1;
            end else begin
              bit_q   <= bit_q + 3'd1;
              shift_q <= {1'b0, shift_q[7:1]};
              tx_q    <= shift_q[1];
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StStop: begin
          if (tick) begin
            cnt_q <= '0;
            if (byte_valid) begin
              state_q <= StStart;
              shift_q <= byte_data;
              tx_q    <= 1'b0;
            end else begin
              state_q <= StIdle;
            end
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        default: begin
          state_q <= StIdle;
          cnt_q   <= '0;
          tx_q    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/heepstor_exit_reporter.sv
// Captures SoC exit values on the rising edge of exit_valid and reports them as
// "EXIT=XXXXXXXX\r\n" over UART plus a status LED. HEEPSTOR_EXIT_BLINK_EN adds fail blinking.
module heepstor_exit_reporter
  import heepstor_exit_pkg::*;
#(
  parameter int unsigned CLK_FREQ_HZ = 100_000_000,
  parameter int unsigned BAUD_RATE   = 115_200,
  parameter int unsigned BLINK_LEN   = 24
) (
  input  logic                     clk_gen,
  input  logic                     rst_n,
  heepstor_exit_reporter_if.slave  exit_if,
  output logic                     uart_tx_o,
  output logic                     busy_o,
  output logic                     exit_led_o
);

  localparam int unsigned DIV = CLK_FREQ_HZ / BAUD_RATE;
  localparam logic [3:0] LastIdx = 4'(MSG_LEN - 1);

  if (BLINK_LEN < 1) begin : g_blink_check
    $error("heepstor_exit_reporter: BLINK_LEN must be at least 1");
  end

  logic        valid_q;
  logic [31:0] cur_q, cur_d;
  logic [31:0] pend_q, pend_d;
  logic        pend_v_q, pend_v_d;
  logic [3:0]  idx_q, idx_d;
  logic        handed_q, handed_d;
  logic        active_q, active_d;
  logic        exit_fail_q, fail_d;
  logic        seen_q, seen_d;
  logic        busy_q, busy_d;

  logic        rise;
  logic        byte_valid, byte_ready, fire, ser_done, msg_done;
  logic [7:0]  byte_data;
  logic [2:0]  pre_sel, nib_sel;

  assign rise = exit_if.exit_valid_i & ~valid_q;

  // Once all 15 bytes are handed off, a pending value can offer its leading 'E' early so
  // the next message follows the last stop bit with no gap.
  assign byte_valid = active_q & (~handed_q | pend_v_q);
  assign fire       = byte_valid & byte_ready;
  assign msg_done   = active_q & handed_q & ~pend_v_q & ser_done;

  assign pre_sel = 3'd4 - idx_q[2:0];
  assign nib_sel = idx_q[2:0] + 3'd3;  // idx 5..12 -> nibble 0..7, MSB nibble first

  always_comb begin
    byte_data = MSG_PREFIX[39:32];
    if (!handed_q) begin
      if (idx_q < 4'd5) begin
        byte_data = MSG_PREFIX[{pre_sel, 3'b000} +: 8];
      end else if (idx_q < 4'd13) begin
        byte_data = hex_ascii(cur_q[{~nib_sel, 2'b00} +: 4]);
      end else if (idx_q == 4'd13) begin
        byte_data = ASCII_CR;
      end else begin
        byte_data = ASCII_LF;
      end
    end
  end

  always_comb begin
    cur_d    = cur_q;
    pend_d   = pend_q;
    pend_v_d = pend_v_q;
    idx_d    = idx_q;
    handed_d = handed_q;
    active_d = active_q;
    fail_d   = exit_fail_q;
    seen_d   = seen_q;
    if (active_q) begin
      if (fire) begin
        if (handed_q) begin
          // Leading 'E' of the pending message just went out; continue from index 1.
          cur_d    = pend_q;
          idx_d    = 4'd1;
          handed_d = 1'b0;
          pend_v_d = 1'b0;
          fail_d   = (pend_q != '0);
        end else if (idx_q == LastIdx) begin
          handed_d = 1'b1;
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      if (msg_done) begin
        active_d = 1'b0;
        handed_d = 1'b0;
        idx_d    = '0;
      end
      if (rise) begin
        pend_d   = exit_if.exit_value_i;
        pend_v_d = 1'b1;
      end
    end else if (rise || pend_v_q) begin
      cur_d    = rise ? exit_if.exit_value_i : pend_q;
      pend_v_d = 1'b0;
      idx_d    = '0;
      handed_d = 1'b0;
      active_d = 1'b1;
      fail_d   = (cur_d != '0);
      seen_d   = 1'b1;
    end
    busy_d = (active_q & ~msg_done) | pend_v_q | pend_v_d;
  end

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      cur_q       <= '0;
      pend_q      <= '0;
      pend_v_q    <= 1'b0;
      idx_q       <= '0;
      handed_q    <= 1'b0;
      active_q    <= 1'b0;
      exit_fail_q <= 1'b0;
      seen_q      <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      valid_q     <= exit_if.exit_valid_i;
      cur_q       <= cur_d;
      pend_q      <= pend_d;
      pend_v_q    <= pend_v_d;
      idx_q       <= idx_d;
      handed_q    <= handed_d;
      active_q    <= active_d;
      exit_fail_q <= fail_d;
      seen_q      <= seen_d;
      busy_q      <= busy_d;
    end
  end

  heepstor_uart_tx_byte #(
    .DIV (DIV)
  ) u_tx (
    .clk_gen    (clk_gen),
    .rst_n      (rst_n),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .done       (ser_done),
    .tx         (uart_tx_o)
  );

  assign busy_o = busy_q;

`ifdef HEEPSTOR_EXIT_BLINK_EN
  logic [BLINK_LEN-1:0] blink_q;

  always_ff @(posedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      blink_q <= '0;
    end else if (seen_q) begin
      blink_q <= blink_q + BLINK_LEN'(1);
    end
  end

  assign exit_led_o = seen_q & (exit_fail_q ? blink_q[BLINK_LEN-1] : 1'b1);
`else
  assign exit_led_o = seen_q & ~exit_fail_q;
`endif

endmodule

// File: tb/tb_heepstor_exit_reporter.sv
// Self-checking bench for heepstor_exit_reporter: a mid-bit UART decoder fills rx_q and
// each scenario compares it against lines it queued in exp_q.
module tb_heepstor_exit_reporter;

  localparam int unsigned CLK_FREQ_HZ = 1_000_000;
  localparam int unsigned BAUD_RATE   = 100_000;
  localparam int unsigned DIV         = 10;
  localparam int unsigned BLINK_LEN   = 4;

  logic clk_gen = 1'b0;
  logic rst_n   = 1'b0;
  logic uart_tx, busy, exit_led;

  heepstor_exit_reporter_if exit_if ();

  heepstor_exit_reporter #(
    .CLK_FREQ_HZ (CLK_FREQ_HZ),
    .BAUD_RATE   (BAUD_RATE),
    .BLINK_LEN   (BLINK_LEN)
  ) dut (
    .clk_gen    (clk_gen),
    .rst_n      (rst_n),
    .exit_if    (exit_if),
    .uart_tx_o  (uart_tx),
    .busy_o     (busy),
    .exit_led_o (exit_led)
  );

  always #5 clk_gen = ~clk_gen;

  int n_vec = 0;
  int n_err = 0;
  int frame_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_q[$];

  // Decoder: negedge c after start detection sits at c+0.5 cycles into the frame.
  logic       mon_on = 1'b0;
  int         mon_cnt = 0;
  logic [7:0] mon_sh = '0;

  always @(negedge clk_gen or negedge rst_n) begin
    if (!rst_n) begin
      mon_on  <= 1'b0;
      mon_cnt <= 0;
    end else if (!mon_on) begin
      if (uart_tx === 1'b0) begin
        mon_on  <= 1'b1;
        mon_cnt <= 1;
      end
    end else begin
      mon_cnt <= mon_cnt + 1;
      if (mon_cnt == DIV / 2 - 1) begin
        if (uart_tx !== 1'b0) frame_err <= frame_err + 1;
      end else if (mon_cnt == 10 * DIV - DIV / 2 - 1) begin
        if (uart_tx !== 1'b1) frame_err <= frame_err + 1;
        rx_q.push_back(mon_sh);
        mon_on <= 1'b0;
      end else if (((mon_cnt - (DIV / 2 - 1)) % DIV) == 0) begin
        mon_sh <= {uart_tx, mon_sh[7:1]};
      end
    end
  end

  task automatic push_line(input logic [31:0] v);
    logic [3:0] d;
    exp_q.push_back("E"); exp_q.push_back("X"); exp_q.push_back("I");
    exp_q.push_back("T"); exp_q.push_back("=");
    for (int i = 7; i >= 0; i--) begin
      d = v[i*4 +: 4];
      exp_q.push_back((d < 10) ? (8'd48 + 8'(d)) : (8'd65 + 8'(d) - 8'd10));
    end
    exp_q.push_back(8'h0D);
    exp_q.push_back(8'h0A);
  endtask

  task automatic pulse_start(input logic [31:0] v);
    @(negedge clk_gen);
    exit_if.exit_value_i = v;
    exit_if.exit_valid_i = 1'b1;
  endtask

  task automatic test_reset;
    int bad = 0;
    exit_if.exit_valid_i = 1'b0;
    exit_if.exit_value_i = '0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_gen);
    n_vec++;
    if ({uart_tx, busy, exit_led} !== 3'b100) begin
      n_err++;
      $display("FAIL reset_values: tx/busy/led=%b required 100", {uart_tx, busy, exit_led});
    end
    rst_n = 1'b1;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk_gen);
      if ({uart_tx, busy, exit_led} !== 3'b100) bad++;
    end
    n_vec++;
    if (bad != 0 || rx_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_1000: bad cycles=%0d rx bytes=%0d required 0/0", bad, rx_q.size());
    end
  endtask

  task automatic test_single;
    int lat_tx = -1, lat_busy = -1, busy_len = 0;
    logic [7:0] got, want;
    push_line(32'h0000_002A);
    pulse_start(32'h0000_002A);
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk_gen);
      if (k == 1) exit_if.exit_valid_i = 1'b0;
      if (uart_tx === 1'b0 && lat_tx < 0) lat_tx = k;
      if (busy === 1'b1) begin
        if (lat_busy < 0) lat_busy = k;
        busy_len++;
      end else if (lat_busy >= 0) begin
        break;
      end
    end
    n_vec++;
    if (lat_tx != 2) begin
      n_err++; $display("FAIL single_tx_latency: got %0d required 2", lat_tx);
    end
    n_vec++;
    if (lat_busy != 2) begin
      n_err++; $display("FAIL single_busy_latency: got %0d required 2", lat_busy);
    end
    n_vec++;
    if (busy_len != 150 * DIV) begin
      n_err++; $display("FAIL single_busy_len: got %0d required %0d", busy_len, 150 * DIV);
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL single_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL single_byte: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
`ifdef HEEPSTOR_EXIT_BLINK_EN
    begin
      bit s0 = 0, s1 = 0;
      for (int k = 0; k < 64; k++) begin
        @(negedge clk_gen);
        if (exit_led === 1'b0) s0 = 1;
        if (exit_led === 1'b1) s1 = 1;
      end
      n_vec++;
      if (!(s0 && s1)) begin
        n_err++; $display("FAIL single_led_blink: saw0=%0d saw1=%0d required 1/1", s0, s1);
      end
    end
`else
    n_vec++;
    if (exit_led !== 1'b0) begin
      n_err++; $display("FAIL single_led_fail: got %b required 0", exit_led);
    end
`endif
  endtask

  task automatic test_hold;
    int off = 0;
    logic [7:0] got, want;
    push_line(32'h0);
    pulse_start(32'h0);
    repeat (5000) @(negedge clk_gen);
    exit_if.exit_valid_i = 1'b0;
    repeat (20) @(negedge clk_gen);
    n_vec++;
    if (rx_q.size() != exp_q.size() || busy !== 1'b0) begin
      n_err++;
      $display("FAIL hold_count: got %0d bytes busy=%b required %0d bytes busy=0",
               rx_q.size(), busy, exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL hold_byte: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
    for (int k = 0; k < 100; k++) begin
      @(negedge clk_gen);
      if (exit_led !== 1'b1) off++;
    end
    n_vec++;
    if (off != 0) begin
      n_err++; $display("FAIL hold_led_pass: cycles off=%0d required 0", off);
    end
  endtask

  task automatic test_back_to_back;
    int busy_len = 0;
    bit started = 0;
    logic [7:0] got, want;
    push_line(32'hDEAD_BEEF);
    push_line(32'h0000_0002);
    pulse_start(32'hDEAD_BEEF);
    for (int k = 1; k <= 6000; k++) begin
      @(negedge clk_gen);
      if (k == 1 || k == 301 || k == 401) exit_if.exit_valid_i = 1'b0;
      if (k == 300) begin exit_if.exit_value_i = 32'h1; exit_if.exit_valid_i = 1'b1; end
      if (k == 400) begin exit_if.exit_value_i = 32'h2; exit_if.exit_valid_i = 1'b1; end
      if (busy === 1'b1) begin
        started = 1; busy_len++;
      end else if (started) begin
        break;
      end
    end
    n_vec++;
    if (busy_len != 300 * DIV) begin
      n_err++; $display("FAIL b2b_busy_len: got %0d required %0d", busy_len, 300 * DIV);
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL b2b_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL b2b_byte: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  // Second rise lands in the final cycle of the last stop bit.
  task automatic test_edge_rise;
    int falls = 0;
    logic prev = 1'b0;
    logic [7:0] got, want;
    push_line(32'h0000_FFFF);
    push_line(32'h8000_0000);
    pulse_start(32'h0000_FFFF);
    for (int k = 1; k <= 3600; k++) begin
      @(negedge clk_gen);
      if (k == 1 || k == 1502) exit_if.exit_valid_i = 1'b0;
      if (k == 1501) begin exit_if.exit_value_i = 32'h8000_0000; exit_if.exit_valid_i = 1'b1; end
      if (prev === 1'b1 && busy === 1'b0) falls++;
      prev = busy;
    end
    n_vec++;
    if (falls != 1 || busy !== 1'b0) begin
      n_err++; $display("FAIL edge_busy_falls: got %0d busy=%b required 1 busy=0", falls, busy);
    end
    n_vec++;
    if (rx_q.size() != exp_q.size()) begin
      n_err++; $display("FAIL edge_count: got %0d bytes required %0d", rx_q.size(), exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL edge_byte: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  task automatic test_reset_mid;
    int busy_len = 0;
    bit started = 0;
    logic [7:0] got, want;
    push_line(32'h1234_5678);
    pulse_start(32'h1234_5678);
    for (int k = 1; k < 700; k++) begin
      @(negedge clk_gen);
      if (k == 1) exit_if.exit_valid_i = 1'b0;
    end
    @(negedge clk_gen);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({uart_tx, busy, exit_led} !== 3'b100) begin
      n_err++;
      $display("FAIL midreset_values: tx/busy/led=%b required 100", {uart_tx, busy, exit_led});
    end
    n_vec++;
    if (rx_q.size() == 0 || rx_q.size() >= 15) begin
      n_err++; $display("FAIL midreset_partial: got %0d bytes required 1..14", rx_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL midreset_prefix: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
    repeat (3) @(negedge clk_gen);
    rst_n = 1'b1;
    repeat (5) @(negedge clk_gen);
    push_line(32'hCAFE_0001);
    pulse_start(32'hCAFE_0001);
    for (int k = 1; k <= 3000; k++) begin
      @(negedge clk_gen);
      if (k == 1) exit_if.exit_valid_i = 1'b0;
      if (busy === 1'b1) begin
        started = 1; busy_len++;
      end else if (started) begin
        break;
      end
    end
    n_vec++;
    if (busy_len != 150 * DIV || rx_q.size() != exp_q.size()) begin
      n_err++;
      $display("FAIL midreset_resend: busy=%0d bytes=%0d required %0d/%0d",
               busy_len, rx_q.size(), 150 * DIV, exp_q.size());
    end
    while (exp_q.size() > 0 && rx_q.size() > 0) begin
      got = rx_q.pop_front(); want = exp_q.pop_front(); n_vec++;
      if (got !== want) begin
        n_err++; $display("FAIL midreset_byte: got %h required %h", got, want);
      end
    end
    exp_q.delete(); rx_q.delete();
  endtask

  initial begin
    exit_if.exit_valid_i = 1'b0;
    exit_if.exit_value_i = '0;
    test_reset();
    test_single();
    test_hold();
    test_back_to_back();
    test_edge_rise();
    test_reset_mid();
    n_vec++;
    if (frame_err != 0) begin
      n_err++; $display("FAIL framing: errors=%0d required 0", frame_err);
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
